// File: rtl/uart_pkg.sv
// Shared types and constants for the memory-mapped UART transmit port.
package uart_pkg;

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } txState_t;

  localparam int BUSY      = 0;
  localparam int EMPTY     = 1;
  localparam int FULL      = 2;
  localparam int OVERFLOW  = 3;
  localparam int COUNT_LSB = 4;

  localparam int DATA_BITS  = 8;
  localparam int FRAME_BITS = 10;

endpackage

// File: rtl/tx_byte_fifo.sv
// Byte FIFO feeding the transmitter; count is kept alongside the pointers so full/empty never alias.
module tx_byte_fifo #(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                               clk,
  input  logic                               reset,
  input  logic                               push,
  input  logic                               pop,
  input  logic [7:0]                         din,
  output logic [7:0]                         dout,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    count,
  output logic                               full,
  output logic                               empty
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int PW = $clog2(FIFO_DEPTH);

  logic [7:0]    mem [FIFO_DEPTH];
  logic [PW-1:0] rdPtr;
  logic [PW-1:0] wrPtr;
  logic          doPush;
  logic          doPop;

  // A pop on the same edge frees the head slot, so a push into a full FIFO is still legal then.
  assign doPop  = pop && !empty;
  assign doPush = push && (!full || doPop);
  assign full   = (count == CW'(FIFO_DEPTH));
  assign empty  = (count == '0);
  assign dout   = mem[rdPtr];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      rdPtr <= '0;
      wrPtr <= '0;
      count <= '0;
    end else begin
      if (doPush) wrPtr <= wrPtr + 1'b1;
      if (doPop)  rdPtr <= rdPtr + 1'b1;
      case ({doPush, doPop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (doPush) mem[wrPtr] <= din;
  end

endmodule

// File: rtl/uart_tx_port.sv
// 8N1 UART transmit port: queues processor stores and serialises them LSB first,
// reporting a registered status word back on the port-in path.
module uart_tx_port
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        WriteEnable,
  input  logic [7:0]  WriteData,
  input  logic        ClearOverflow,
  output logic        TxSerial,
  output logic [31:0] Status
);

  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int BW = $clog2(CLKS_PER_BIT);

  txState_t      state;
  txState_t      stateNext;
  logic [BW-1:0] bcnt;
  logic [BW-1:0] bcntNext;
  logic [2:0]    bidx;
  logic [2:0]    bidxNext;
  logic [7:0]    shiftReg;
  logic [7:0]    shiftNext;
  logic          txNext;
  logic          bitDone;
  logic          overflow;
  logic          busy;
  logic [31:0]   statusNext;

  logic          fifoPop;
  logic [7:0]    fifoDout;
  logic [CW-1:0] fifoCount;
  logic          fifoFull;
  logic          fifoEmpty;

  tx_byte_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) fifo (
    .clk   (clk),
    .reset (reset),
    .push  (WriteEnable),
    .pop   (fifoPop),
    .din   (WriteData),
    .dout  (fifoDout),
    .count (fifoCount),
    .full  (fifoFull),
    .empty (fifoEmpty)
  );

  assign bitDone = (bcnt == BW'(CLKS_PER_BIT - 1));
  assign busy    = (state != IDLE) || !fifoEmpty;

  // txNext is the line level for the current state; it is registered so the line never glitches.
  always_comb begin
    stateNext = state;
    bcntNext  = bcnt;
    bidxNext  = bidx;
    shiftNext = shiftReg;
    fifoPop   = 1'b0;
    txNext    = 1'b1;
    case (state)
      IDLE: begin
        bcntNext = '0;
        if (!fifoEmpty) begin
          fifoPop   = 1'b1;
          shiftNext = fifoDout;
          stateNext = START;
        end
      end
      START: begin
        txNext = 1'b0;
        if (bitDone) begin
          bcntNext  = '0;
          bidxNext  = '0;
          stateNext = DATA;
        end else begin
          bcntNext = bcnt + 1'b1;
        end
      end
      DATA: begin
        txNext = shiftReg[0];
        if (bitDone) begin
          bcntNext  = '0;
          shiftNext = shiftReg >> 1;
          if (bidx == 3'(DATA_BITS - 1)) stateNext = STOP;
          else                           bidxNext  = bidx + 1'b1;
        end else begin
          bcntNext = bcnt + 1'b1;
        end
      end
      STOP: begin
        if (bitDone) begin
          bcntNext  = '0;
          stateNext = IDLE;
        end else begin
          bcntNext = bcnt + 1'b1;
        end
      end
      default: stateNext = IDLE;
    endcase
  end

  always_comb begin
    statusNext                   = '0;
    statusNext[BUSY]             = busy;
    statusNext[EMPTY]            = fifoEmpty;
    statusNext[FULL]             = fifoFull;
    statusNext[OVERFLOW]         = overflow;
    statusNext[COUNT_LSB +: 8]   = 8'(fifoCount);
  end

  // A write dropped by a full FIFO takes priority over a same-cycle clear of the sticky flag.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      bcnt     <= '0;
      bidx     <= '0;
      shiftReg <= '0;
      TxSerial <= 1'b1;
      overflow <= 1'b0;
      Status   <= 32'h0000_0002;
    end else begin
      state    <= stateNext;
      bcnt     <= bcntNext;
      bidx     <= bidxNext;
      shiftReg <= shiftNext;
      TxSerial <= txNext;
      if (WriteEnable && fifoFull && !fifoPop) overflow <= 1'b1;
      else if (ClearOverflow)                  overflow <= 1'b0;
      Status   <= statusNext;
    end
  end

endmodule

// File: tb/tb_uart_tx_port.sv
// Bench for uart_tx_port: directed and random writes checked every cycle against a
// frame-timing model of the queue and the serial line.
module tb_uart_tx_port;

  localparam int CPB   = 16;
  localparam int DEPTH = 4;
  localparam int FRAME = 10 * CPB;

  logic        clk = 1'b0;
  logic        reset;
  logic        WriteEnable;
  logic [7:0]  WriteData;
  logic        ClearOverflow;
  logic        TxSerial;
  logic [31:0] Status;

  int checkCount = 0;
  int failCount  = 0;

  logic [7:0] mdlQ[$];
  logic [7:0] mdlFrame;
  int         lastPop;
  int         txFree;
  logic       mdlOvf;
  int         edgeNum;

  always #5 clk = ~clk;

  uart_tx_port #(
    .CLKS_PER_BIT(CPB),
    .FIFO_DEPTH  (DEPTH)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .WriteEnable  (WriteEnable),
    .WriteData    (WriteData),
    .ClearOverflow(ClearOverflow),
    .TxSerial     (TxSerial),
    .Status       (Status)
  );

  // A frame occupies the transmitter for FRAME edges after the pop edge, plus one idle edge.
  function automatic logic mdlFsmBusy(int x);
    return (x >= lastPop) && (x < lastPop + FRAME);
  endfunction

  function automatic logic [31:0] mdlStatus();
    logic [31:0] s;
    int          n;
    n = mdlQ.size();
    s = '0;
    s[0]    = mdlFsmBusy(edgeNum) || (n != 0);
    s[1]    = (n == 0);
    s[2]    = (n == DEPTH);
    s[3]    = mdlOvf;
    s[11:4] = 8'(n);
    return s;
  endfunction

  function automatic logic mdlLine(int e);
    int o;
    o = e - lastPop - 1;
    if (o < 0 || o >= FRAME) return 1'b1;
    if (o < CPB) return 1'b0;
    if (o < 9 * CPB) return mdlFrame[(o - CPB) / CPB];
    return 1'b1;
  endfunction

  task automatic mdlReset();
    mdlQ.delete();
    lastPop = -1000000;
    txFree  = 0;
    mdlOvf  = 1'b0;
  endtask

  task automatic mdlEdge(input logic we, input logic [7:0] data, input logic clr);
    logic setOvf;
    setOvf = 1'b0;
    if (edgeNum >= txFree && mdlQ.size() > 0) begin
      mdlFrame = mdlQ.pop_front();
      lastPop  = edgeNum;
      txFree   = edgeNum + FRAME + 1;
    end
    if (we) begin
      if (mdlQ.size() < DEPTH) mdlQ.push_back(data);
      else                     setOvf = 1'b1;
    end
    if (setOvf)   mdlOvf = 1'b1;
    else if (clr) mdlOvf = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    assert (obs === exp) else begin
      failCount++;
      $error("[TB] FAIL %s: observed %h expected %h at edge %0d", tag, obs, exp, edgeNum);
    end
  endtask

  task automatic applyStimulus(input logic we, input logic [7:0] data, input logic clr);
    logic [31:0] expStatus;
    WriteEnable   = we;
    WriteData     = data;
    ClearOverflow = clr;
    expStatus     = mdlStatus();
    @(posedge clk);
    edgeNum++;
    mdlEdge(we, data, clr);
    #1;
    WriteEnable   = 1'b0;
    ClearOverflow = 1'b0;
    checkOutput("txSerial", {31'b0, TxSerial}, {31'b0, mdlLine(edgeNum)});
    checkOutput("status", Status, expStatus);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    logic ready;
    reset         = 1'b1;
    WriteEnable   = 1'b0;
    WriteData     = 8'h00;
    ClearOverflow = 1'b0;
    edgeNum       = 0;
    mdlReset();

    repeat (3) @(posedge clk);
    #1;
    checkOutput("resetTx", {31'b0, TxSerial}, 32'h1);
    checkOutput("resetStatus", Status, 32'h0000_0002);
    @(negedge clk) reset = 1'b0;

    idleCycles(50);

    $display("[TB] single byte A5");
    applyStimulus(1'b1, 8'hA5, 1'b0);
    idleCycles(FRAME + 10);

    $display("[TB] five back-to-back bytes");
    for (int i = 1; i <= 5; i++) applyStimulus(1'b1, 8'(i), 1'b0);
    idleCycles(5 * (FRAME + 1) + 10);

    $display("[TB] overflow while full");
    applyStimulus(1'b1, 8'h10, 1'b0);
    for (int i = 0; i < 4; i++) applyStimulus(1'b1, 8'h20 + 8'(i), 1'b0);
    applyStimulus(1'b1, 8'hFF, 1'b0);
    applyStimulus(1'b1, 8'hEE, 1'b1);
    idleCycles(2);
    checkOutput("overflowStatus", Status, 32'h0000_004D);
    applyStimulus(1'b0, 8'h00, 1'b1);
    idleCycles(5 * (FRAME + 1) + 10);

    $display("[TB] reset mid-frame");
    applyStimulus(1'b1, 8'hA5, 1'b0);
    idleCycles(41);
    reset = 1'b1;
    #2;
    checkOutput("midResetTx", {31'b0, TxSerial}, 32'h1);
    checkOutput("midResetStatus", Status, 32'h0000_0002);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("heldResetStatus", Status, 32'h0000_0002);
    mdlReset();
    @(negedge clk) reset = 1'b0;
    applyStimulus(1'b1, 8'h3C, 1'b0);
    idleCycles(FRAME + 10);

    $display("[TB] push and pop on the same edge while full");
    applyStimulus(1'b1, 8'h40, 1'b0);
    for (int i = 1; i <= 4; i++) applyStimulus(1'b1, 8'h40 + 8'(i), 1'b0);
    ready = 1'b0;
    for (int k = 0; k < 2 * FRAME && !ready; k++) begin
      ready = (edgeNum + 1 >= txFree) && (mdlQ.size() == DEPTH);
      if (!ready) applyStimulus(1'b0, 8'h00, 1'b0);
    end
    checkOutput("fullPopReached", {31'b0, ready}, 32'h1);
    applyStimulus(1'b1, 8'h77, 1'b0);
    idleCycles(2);
    checkOutput("fullPopStatus", Status, 32'h0000_0045);
    idleCycles(5 * (FRAME + 1) + 10);

    $display("[TB] random traffic");
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 59) == 0, 8'($urandom), $urandom_range(0, 99) == 0);
    end
    idleCycles(5 * (FRAME + 1) + 10);

    $display("%0d/%0d checks passed", checkCount - failCount, checkCount);
    $finish;
  end

endmodule
